and_d6_slice: RTL and testbench
===============================

# and_d6_slice

Four-lane 6-input lookup-table slice. Each lane evaluates one 64-entry truth table (INIT), shared by all lanes, over its own six input bits. It is the leaf primitive of the fractcam match-reduction tree: the and6 reducer programs INIT as an N-input AND (N = 2..6) and tiles slices across the match vector, four entries per slice. An optional output register, on one clock with asynchronous active-low reset, allows pipelining the reduction tree.

## Interface
- INIT, default 64'h8000_0000_0000_0000: truth table, identical for all four lanes. Default is a 6-input AND.
- OUT_REG, default 1: 1 = registered output; 0 = purely combinational output.
- clk  in  1  rising-edge clock; used only when OUT_REG=1.
- rst_n  in  1  reset, asynchronous, active-low; used only when OUT_REG=1.
- i0  in  4  LUT address bit 0 for lanes 3..0 (bit k feeds lane k).
- i1  in  4  LUT address bit 1, per lane.
- i2  in  4  LUT address bit 2, per lane.
- i3  in  4  LUT address bit 3, per lane.
- i4  in  4  LUT address bit 4, per lane.
- i5  in  4  LUT address bit 5, per lane.
- o  out  4  lane results; o[k] belongs to lane k.

## Operation
- Lane k, for k = 0..3:
  - address a_k = {i5[k], i4[k], i3[k], i2[k], i1[k], i0[k]}, a 6-bit unsigned value.
  - result r_k = INIT[a_k], so i5 is the MSB and INIT bit 63 is selected when all inputs are 1.
- Lanes are fully independent; there is no cross-lane logic.
- Each lane is one 6-input LUT (LUT6 on Xilinx targets) with INIT passed straight through. Each lane carries a keep/dont_touch attribute so synthesis neither merges nor re-maps it.
- Reference INIT encodings (unused inputs tied to 1 by the caller):
  - 64'h8888_8888_8888_8888 = AND(i0, i1) when i2..i5 are all 1.
  - 64'h8080_8080_8080_8080 = AND(i0..i2).
  - 64'h8000_8000_8000_8000 = AND(i0..i3).
  - 64'h8000_0000_8000_0000 = AND(i0..i4).
  - 64'h8000_0000_0000_0000 = AND(i0..i5).
- No state other than the optional output register. No handshake; every cycle is valid.

## Timing
- OUT_REG=1:
  - o[k] <= r_k on every rising clk edge.
  - Latency is 1 cycle from input to output; throughput is 1 result per cycle per lane.
  - Reset: rst_n low clears o to 4'h0 immediately, independent of clk, and holds it while rst_n stays low.
  - Reset mid-operation discards the in-flight result.
  - The first rising edge with rst_n high captures the current inputs.
  - Reset value of o is 4'h0 regardless of INIT.
- OUT_REG=0:
  - o[k] = r_k combinationally, with zero latency.
  - clk and rst_n are ignored and no flops are inferred.
  - Inputs changing between edges propagate directly to o.
- X or Z on any address bit of a lane may make that lane X. Other lanes are unaffected.

## Test plan
- Default INIT, OUT_REG=1: all inputs 4'hF -> o = 4'hF one cycle later. Then set i3 = 4'b1011 -> o = 4'b1011 on the next cycle.
- INIT=64'h8888_8888_8888_8888, i2..i5 = 4'hF, OUT_REG=1: i0 = 4'b1100, i1 = 4'b1010 -> o = 4'b1000 after 1 cycle. Sweep all 256 (i0, i1) combinations -> o always equals i0 & i1, delayed by 1 cycle.
- INIT=64'h8080_8080_8080_8080: i0..i2 = 4'hF with i3..i5 random -> o = 4'hF. Set i2[1]=0 -> o[1]=0.
- Random INIT plus exhaustive 64-address sweep on each lane independently -> o[k] == INIT[a_k] for every address, every lane.
- Reset:
  - o = 4'hF steady, assert rst_n low between clock edges -> o = 4'h0 immediately, and stays 4'h0 while inputs toggle.
  - Deassert rst_n -> o follows the inputs from the next edge.
- OUT_REG=0, default INIT: toggle i5 with clk stopped -> o tracks AND(i0..i5) within the same delta. rst_n low has no effect on o.

Source files
------------

// File: rtl/and_d6_slice.sv
// Four-lane 6-input LUT slice sharing one INIT truth table; leaf of the match-reduction tree.
// Latency: 1 cycle when OUT_REG=1, 0 (combinational) when OUT_REG=0.
// Backpressure: none; every cycle is valid and each lane produces one result per cycle.
module and_d6_slice #(
    parameter logic [63:0] INIT    = 64'h8000_0000_0000_0000,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic [3:0] i2,
    input  logic [3:0] i3,
    input  logic [3:0] i4,
    input  logic [3:0] i5,
    output logic [3:0] o
);

    logic [3:0] r;

    // One LUT per lane, kept distinct so the tree keeps its intended mapping.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [5:0] addr;
        (* keep = "true", dont_touch = "true" *) logic lut_out;

        assign addr    = {i5[k], i4[k], i3[k], i2[k], i1[k], i0[k]};
        assign lut_out = INIT[addr];
        assign r[k]    = lut_out;
    end

    if (OUT_REG) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o <= 4'h0;
            end else begin
                o <= r;
            end
        end
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign o = r;
    end

endmodule

// File: tb/tb_and_d6_slice.sv
// Directed bench for and_d6_slice: table vectors plus sweeps, reset and combinational corner cases.
module tb_and_d6_slice;

    localparam logic [63:0] AND6_INIT = 64'h8000_0000_0000_0000;
    localparam logic [63:0] AND2_INIT = 64'h8888_8888_8888_8888;
    localparam logic [63:0] AND3_INIT = 64'h8080_8080_8080_8080;
    localparam logic [63:0] RND_INIT  = 64'hD3A5_1C7E_9B04_F268;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n;
    logic [3:0] i0, i1, i2, i3, i4, i5;
    logic [3:0] o_def, o_and2, o_and3, o_rnd, o_comb;

    int tests = 0;
    int fails = 0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    and_d6_slice u_def (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .o(o_def)
    );
    and_d6_slice #(.INIT(AND2_INIT), .OUT_REG(1'b1)) u_and2 (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .o(o_and2)
    );
    and_d6_slice #(.INIT(AND3_INIT), .OUT_REG(1'b1)) u_and3 (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .o(o_and3)
    );
    and_d6_slice #(.INIT(RND_INIT), .OUT_REG(1'b1)) u_rnd (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .o(o_rnd)
    );
    and_d6_slice #(.INIT(AND6_INIT), .OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .o(o_comb)
    );

    typedef struct {
        logic [3:0] i0, i1, i2, i3, i4, i5;
        logic [3:0] exp_and6;
        logic [3:0] exp_and2;
        logic [3:0] exp_and3;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a0, a1, a2, a3, a4, a5);
        i0 = a0; i1 = a1; i2 = a2; i3 = a3; i4 = a4; i5 = a5;
    endtask

    initial begin
        //                i0     i1     i2     i3     i4     i5     and6   and2   and3
        tbl[0] = '{4'hF,  4'hF,  4'hF,  4'hF,  4'hF,  4'hF,  4'hF,  4'hF,  4'hF};
        tbl[1] = '{4'hF,  4'hF,  4'hF,  4'hB,  4'hF,  4'hF,  4'hB,  4'hF,  4'hF};
        tbl[2] = '{4'hC,  4'hA,  4'hF,  4'hF,  4'hF,  4'hF,  4'h8,  4'h8,  4'h8};
        tbl[3] = '{4'hF,  4'hF,  4'hF,  4'h5,  4'h3,  4'hE,  4'h0,  4'hF,  4'hF};
        tbl[4] = '{4'hF,  4'hF,  4'hD,  4'h5,  4'h3,  4'hE,  4'h0,  4'hF,  4'hD};
        tbl[5] = '{4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
        tbl[6] = '{4'h6,  4'hF,  4'h3,  4'hF,  4'hF,  4'hF,  4'h2,  4'h6,  4'h2};

        // Reset state
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #1;
        check("reset_def",  o_def,  4'h0);
        check("reset_and2", o_and2, 4'h0);
        check("reset_rnd",  o_rnd,  4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: combinational copy checked before the edge, registered ones after
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            drive(tbl[v].i0, tbl[v].i1, tbl[v].i2, tbl[v].i3, tbl[v].i4, tbl[v].i5);
            #1;
            check($sformatf("vec%0d_comb", v), o_comb, tbl[v].exp_and6);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_and6", v), o_def,  tbl[v].exp_and6);
            check($sformatf("vec%0d_and2", v), o_and2, tbl[v].exp_and2);
            check($sformatf("vec%0d_and3", v), o_and3, tbl[v].exp_and3);
        end

        // Exhaustive (i0, i1) sweep with i2..i5 high
        for (int v = 0; v < 256; v++) begin
            logic [7:0] vv;
            vv = v[7:0];
            @(negedge clk);
            drive(vv[3:0], vv[7:4], 4'hF, 4'hF, 4'hF, 4'hF);
            @(posedge clk);
            #1;
            check($sformatf("sweep2_%0d", v), o_and2, vv[3:0] & vv[7:4]);
        end

        // 64-address sweep on every lane, each lane on a different address sequence
        for (int a = 0; a < 64; a++) begin
            logic [3:0] exp;
            for (int k = 0; k < 4; k++) begin
                logic [5:0] ak;
                ak = 6'(a + 17 * k);
                i0[k] = ak[0]; i1[k] = ak[1]; i2[k] = ak[2];
                i3[k] = ak[3]; i4[k] = ak[4]; i5[k] = ak[5];
                exp[k] = RND_INIT[ak];
            end
            @(posedge clk);
            #1;
            check($sformatf("rnd_addr%0d", a), o_rnd, exp);
            @(negedge clk);
        end

        // Asynchronous reset between edges, held while inputs toggle
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        @(posedge clk);
        #1;
        check("pre_rst_def", o_def, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_def",  o_def,  4'h0);
        check("async_rst_and3", o_and3, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(4'(c * 5), 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", c), o_def, 4'h0);
        end
        @(negedge clk);
        drive(4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF);
        rst_n = 1'b1;
        #1;
        check("rst_release_pre_edge", o_def, 4'h0);
        @(posedge clk);
        #1;
        check("rst_release_first_edge", o_def, 4'h7);

        // Combinational build with the clock stopped
        @(negedge clk);
        clk_run = 1'b0;
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        #1;
        check("comb_i5_low", o_comb, 4'h0);
        i5 = 4'hA;
        #1;
        check("comb_i5_a", o_comb, 4'hA);
        check("stopped_clk_reg_holds", o_def, 4'h7);
        rst_n = 1'b0;
        #1;
        check("comb_ignores_rst", o_comb, 4'hA);
        i5 = 4'h5;
        #1;
        check("comb_i5_5_in_rst", o_comb, 4'h5);
        rst_n = 1'b1;
        clk_run = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
